// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// Optional MADD/MADDU/MSUB/MSUBU enabled by defining MDU_MADD_EN.
module mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] ph, pl, ph_n, pl_n;
    logic [31:0] hi, lo, hi_n, lo_n;

    logic [63:0] sprod, uprod;
    logic [31:0] bd, ma, mb, mq, mr;
    logic [31:0] sq, sr, uq, ur;
    logic        bzero;

    assign sprod = $signed({{32{A[31]}}, A}) *
                   $signed({{32{B[31]}}, B});
    assign uprod = {32'b0, A} * {32'b0, B};

    // Signed divide via magnitudes so MIN/-1 wraps cleanly
    assign bzero = (B == 32'd0);
    assign bd    = bzero ? 32'd1 : B;
    assign ma    = A[31] ? -A : A;
    assign mb    = bd[31] ? -bd : bd;
    assign mq    = ma / mb;
    assign mr    = ma % mb;
    assign sq    = (A[31] ^ bd[31]) ? -mq : mq;
    assign sr    = A[31] ? -mr : mr;
    assign uq    = A / bd;
    assign ur    = A % bd;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ph_n    = ph;
        pl_n    = pl;
        hi_n    = hi;
        lo_n    = lo;
        unique case (state)
            IDLE: begin
                if (Start && !Cancel) begin
                    case (MDUOp)
                        4'b0001: begin
                            {ph_n, pl_n} = sprod;
                            cnt_n   = 4'(MUL_CYCLES);
                            state_n = MUL;
                        end
                        4'b0010: begin
                            {ph_n, pl_n} = uprod;
                            cnt_n   = 4'(MUL_CYCLES);
                            state_n = MUL;
                        end
                        // Divide by zero re-commits the current HI/LO
                        4'b0011: begin
                            ph_n    = bzero ? hi : sr;
                            pl_n    = bzero ? lo : sq;
                            cnt_n   = 4'(DIV_CYCLES);
                            state_n = DIV;
                        end
                        4'b0100: begin
                            ph_n    = bzero ? hi : ur;
                            pl_n    = bzero ? lo : uq;
                            cnt_n   = 4'(DIV_CYCLES);
                            state_n = DIV;
                        end
                        4'b0101: hi_n = A;
                        4'b0110: lo_n = A;
`ifdef MDU_MADD_EN
                        4'b0111: begin
                            {ph_n, pl_n} = {hi, lo} + sprod;
                            cnt_n   = 4'(MUL_CYCLES);
                            state_n = MUL;
                        end
                        4'b1000: begin
                            {ph_n, pl_n} = {hi, lo} + uprod;
                            cnt_n   = 4'(MUL_CYCLES);
                            state_n = MUL;
                        end
                        4'b1001: begin
                            {ph_n, pl_n} = {hi, lo} - sprod;
                            cnt_n   = 4'(MUL_CYCLES);
                            state_n = MUL;
                        end
                        4'b1010: begin
                            {ph_n, pl_n} = {hi, lo} - uprod;
                            cnt_n   = 4'(MUL_CYCLES);
                            state_n = MUL;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (Cancel) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_n = IDLE;
                        hi_n    = ph;
                        lo_n    = pl;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ph    <= 32'd0;
            pl    <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ph    <= ph_n;
            pl    <= pl_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    assign Busy = (state != IDLE);
    assign HI   = hi;
    assign LO   = lo;

endmodule
